// File: rtl/wb_project_selector.sv
// Wishbone-controlled project selector: drives the one-hot `active` enable bus with
// break-before-make switching, a programmable guard time, status/count registers and a done irq.
module wb_project_selector #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned NUM_PROJECTS = 8,
  parameter int unsigned GUARD_RESET  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] active,
  output logic        switch_irq
);

  localparam logic [31:0] PROJ_MASK =
    (NUM_PROJECTS >= 32) ? '1 : ((32'd1 << NUM_PROJECTS) - 32'd1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] active_q, active_d;
  logic        irq_q, irq_d;
  logic [4:0]  sel_id_q, sel_id_d;
  logic        sel_en_q, sel_en_d;
  logic [4:0]  cur_id_q, cur_id_d;
  logic        cur_en_q, cur_en_d;
  logic [7:0]  guard_q, guard_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] count_q, count_d;

  logic        hit, acc, wr;
  logic [1:0]  off;
  logic [31:0] rdata;
  logic        busy;
  logic        req_diff;
  logic        unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[30:8]};

  assign hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc  = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
  assign wr   = acc & wbs_we_i;
  assign off  = wbs_adr_i[3:2];
  assign busy = (state_q == DRAIN);

  // A disabled request matches a disabled current value regardless of id.
  assign req_diff = (sel_en_q != cur_en_q) || (sel_en_q && (sel_id_q != cur_id_q));

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = {sel_en_q, 26'b0, sel_id_q};
      2'd1: rdata = {24'b0, guard_q};
      2'd2: rdata = {15'b0, cur_en_q, 3'b0, cur_id_q, 6'b0, err_q, busy};
      default: rdata = {16'b0, count_q};
    endcase
  end

  always_comb begin
    ack_d    = acc;
    dat_d    = (acc && !wbs_we_i) ? rdata : '0;
    sel_id_d = sel_id_q;
    sel_en_d = sel_en_q;
    guard_d  = guard_q;
    err_d    = err_q;

    if (wr && off == 2'd0) begin
      if (wbs_sel_i[0]) begin
        if ({27'b0, wbs_dat_i[4:0]} < NUM_PROJECTS) sel_id_d = wbs_dat_i[4:0];
        else                                         err_d    = 1'b1;
      end
      if (wbs_sel_i[3]) sel_en_d = wbs_dat_i[31];
    end
    if (wr && off == 2'd1 && wbs_sel_i[0]) guard_d = wbs_dat_i[7:0];
    if (wr && off == 2'd2 && wbs_sel_i[0] && wbs_dat_i[1]) err_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    irq_d    = 1'b0;
    cur_id_d = cur_id_q;
    cur_en_d = cur_en_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (req_diff) begin
          state_d  = DRAIN;
          active_d = '0;
          cnt_d    = guard_q;
        end
      end
      default: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cur_id_d = sel_id_q;
          cur_en_d = sel_en_q;
          active_d = sel_en_q ? (PROJ_MASK & (32'd1 << sel_id_q)) : '0;
          irq_d    = 1'b1;
          count_d  = count_q + 16'd1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      active_q <= '0;
      irq_q    <= 1'b0;
      sel_id_q <= '0;
      sel_en_q <= 1'b0;
      cur_id_q <= '0;
      cur_en_q <= 1'b0;
      guard_q  <= 8'(GUARD_RESET);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      active_q <= active_d;
      irq_q    <= irq_d;
      sel_id_q <= sel_id_d;
      sel_en_q <= sel_en_d;
      cur_id_q <= cur_id_d;
      cur_en_q <= cur_en_d;
      guard_q  <= guard_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign active     = active_q;
  assign switch_irq = irq_q;

endmodule

// File: tb/tb_wb_project_selector.sv
// Directed bench for wb_project_selector: register access, switch timing, irq and reset behaviour.
module tb_wb_project_selector;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] active;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  wb_project_selector #(
    .BASE_ADDR   (BASE),
    .NUM_PROJECTS(8),
    .GUARD_RESET (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .active    (active),
    .switch_irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq) irq_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    got = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("write_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = '0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_o; end
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got) check("read_ack", 32'(got), 32'd1);
  endtask

  // Steps edges until active or irq goes high; n is the number of edges taken.
  task automatic await_switch(input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      n++;
      if (active != 0 || irq) break;
    end
  endtask

  logic [31:0] rd;
  int n, irq0, bad;

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_active", active, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    wb_read(BASE + 32'h8, rd); check("rst_status", rd, 32'h0);
    wb_read(BASE + 32'h4, rd); check("rst_guard", rd, 32'h10);
    wb_read(BASE + 32'hC, rd); check("rst_count", rd, 32'h0);
    @(posedge clk); #1;
    check("idle_dat", dat_o, 32'h0);

    // First switch to project 3, guard 16: 17 zero cycles, active at E18.
    irq0 = irq_cnt;
    wb_write(BASE, 32'h8000_0003, 4'hF);
    await_switch(60, n);
    check("sw3_edges", n, 18);
    check("sw3_active", active, 32'h8);
    check("sw3_irq", 32'(irq), 32'h1);
    @(posedge clk); #1;
    check("sw3_irq_off", 32'(irq), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("sw3_irq_cnt", irq_cnt - irq0, 1);
    wb_read(BASE + 32'hC, rd); check("sw3_count", rd, 32'h1);
    wb_read(BASE + 32'h8, rd); check("sw3_status", rd, 32'h0001_0300);

    // Two writes two cycles apart: one guard period, last write wins.
    irq0 = irq_cnt;
    wb_write(BASE, 32'h8000_0005, 4'hF);
    @(posedge clk); #1;
    check("sw2_drop", active, 32'h0);
    wb_write(BASE, 32'h8000_0002, 4'hF);
    await_switch(60, n);
    check("sw2_edges", n, 16);
    check("sw2_active", active, 32'h4);
    check("sw2_irq", 32'(irq), 32'h1);
    repeat (25) @(posedge clk);
    #1;
    check("sw2_hold", active, 32'h4);
    check("sw2_irq_cnt", irq_cnt - irq0, 1);
    wb_read(BASE + 32'hC, rd); check("sw2_count", rd, 32'h2);

    // Invalid id: id kept, err set, no switch; then W1C clears err.
    irq0 = irq_cnt;
    wb_write(BASE, 32'h8000_0009, 4'hF);
    wb_read(BASE, rd); check("bad_sel", rd, 32'h8000_0002);
    wb_read(BASE + 32'h8, rd); check("bad_status", rd, 32'h0001_0202);
    wb_write(BASE + 32'h8, 32'h2, 4'h1);
    wb_read(BASE + 32'h8, rd); check("err_clr", rd, 32'h0001_0200);
    check("bad_no_irq", irq_cnt - irq0, 0);
    check("bad_active", active, 32'h4);

    // Guard 0: active low for exactly one cycle.
    wb_write(BASE + 32'h4, 32'h0, 4'hF);
    irq0 = irq_cnt;
    wb_write(BASE, 32'h8000_0006, 4'hF);
    await_switch(20, n);
    check("g0_edges", n, 2);
    check("g0_active", active, 32'h40);
    check("g0_irq", 32'(irq), 32'h1);
    // Rewrite of the current value must not disturb anything.
    wb_write(BASE, 32'h8000_0006, 4'hF);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (active != 32'h40) bad++;
    end
    check("rewr_glitch", bad, 0);
    check("rewr_irq_cnt", irq_cnt - irq0, 1);
    wb_read(BASE + 32'hC, rd); check("rewr_count", rd, 32'h3);

    // Switch to disabled: drain and irq still happen, active stays 0.
    irq0 = irq_cnt;
    wb_write(BASE, 32'h0000_0006, 4'hF);
    await_switch(20, n);
    check("dis_edges", n, 2);
    check("dis_active", active, 32'h0);
    check("dis_irq", 32'(irq), 32'h1);
    wb_read(BASE + 32'hC, rd); check("dis_count", rd, 32'h4);

    // Reset during DRAIN.
    wb_write(BASE + 32'h4, 32'h0A, 4'h1);
    wb_write(BASE, 32'h8000_0001, 4'hF);
    wb_read(BASE + 32'h8, rd);
    wb_read(BASE + 32'h8, rd); check("drain_status", rd, 32'h0000_0601);
    irq0 = irq_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_active", active, 32'h0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (active != 0) bad++;
    end
    check("mid_rst_hold", bad, 0);
    check("mid_rst_irq", irq_cnt - irq0, 0);
    wb_read(BASE, rd); check("mid_rst_sel", rd, 32'h0);
    wb_read(BASE + 32'h4, rd); check("mid_rst_guard", rd, 32'h10);
    wb_read(BASE + 32'hC, rd); check("mid_rst_count", rd, 32'h0);

    // Undecoded address is never acked.
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) bad++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("nodecode_ack", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
